// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_unit_arbiter                                                            |
// | Round-robin arbiter/sequencer sharing one stb/ack FP unit among N_REQ      |
// | requesters. Optional watchdog enabled by defining ARB_TIMEOUT_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_unit_arbiter #(
   parameter int N_REQ   = 4,
   parameter int IDX_W   = $clog2(N_REQ),
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_stb,
   input  logic [32*N_REQ-1:0] req_a,
   input  logic [32*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]    req_ack,
   output logic [31:0]         resp_z,
   output logic [N_REQ-1:0]    resp_stb,
   input  logic [N_REQ-1:0]    resp_ack,
   output logic                resp_err,
   output logic [31:0]         unit_a,
   output logic [31:0]         unit_b,
   output logic                unit_a_stb,
   output logic                unit_b_stb,
   input  logic                unit_a_ack,
   input  logic                unit_b_ack,
   input  logic [31:0]         unit_z,
   input  logic                unit_z_stb,
   output logic                unit_z_ack,
   output logic                unit_rst,
   output logic                busy,
   output logic [IDX_W-1:0]    grant_idx
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_UNIT_RST = 3'd1,
      S_SEND_A   = 3'd2,
      S_SEND_B   = 3'd3,
      S_WAIT_Z   = 3'd4,
      S_RESP     = 3'd5
   } state_t;

   localparam logic [IDX_W:0]   c_n_req    = (IDX_W+1)'(N_REQ);
   localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(N_REQ-1);
   localparam logic [31:0]      c_qnan     = 32'h7FC0_0000;

   if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_params
      $error("fp_unit_arbiter: unsupported parameter set");
   end

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   r_grant_idx;
   logic [31:0]        r_op_a;
   logic [31:0]        r_op_b;
   logic [31:0]        r_resp_z;
   logic [N_REQ-1:0]   r_req_ack;
   logic               r_unit_z_ack;

   logic [IDX_W:0]     w_sum;
   logic               w_found;
   logic [IDX_W-1:0]   w_winner;
   logic [31:0]        w_win_a;
   logic [31:0]        w_win_b;
   logic [N_REQ-1:0]   w_win_oh;
   logic [N_REQ-1:0]   w_grant_oh;
   logic               w_resp_accept;
   logic               w_state_rst;
   logic               w_timeout;
   logic               w_to_rst;

   // Round-robin search starting just after the last served lane
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last;
      w_sum    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
         if (w_sum >= c_n_req) begin
            w_sum = w_sum - c_n_req;
         end
         if (!w_found && req_stb[w_sum[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      w_win_a    = '0;
      w_win_b    = '0;
      w_win_oh   = '0;
      w_grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == IDX_W'(i)) begin
            w_win_a     = req_a[32*i +: 32];
            w_win_b     = req_b[32*i +: 32];
            w_win_oh[i] = 1'b1;
         end
         w_grant_oh[i] = (r_grant_idx == IDX_W'(i));
      end
   end

   assign w_resp_accept = (r_state == S_RESP) && (|(resp_ack & w_grant_oh));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      unit_a_stb  = 1'b0;
      unit_b_stb  = 1'b0;
      w_state_rst = 1'b0;
      resp_stb    = '0;
      case (r_state)
         S_IDLE: begin
            if (|req_stb) w_next = S_UNIT_RST;
         end
         S_UNIT_RST: begin
            w_state_rst = 1'b1;
            w_next      = S_SEND_A;
         end
         S_SEND_A: begin
            unit_a_stb = 1'b1;
            if (unit_a_ack)     w_next = S_SEND_B;
            else if (w_timeout) w_next = S_RESP;
         end
         S_SEND_B: begin
            unit_b_stb = 1'b1;
            if (unit_b_ack)     w_next = S_WAIT_Z;
            else if (w_timeout) w_next = S_RESP;
         end
         S_WAIT_Z: begin
            if (unit_z_stb)     w_next = S_RESP;
            else if (w_timeout) w_next = S_RESP;
         end
         S_RESP: begin
            resp_stb = w_grant_oh;
            if (w_resp_accept) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last       <= c_last_rst;
         r_grant_idx  <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_resp_z     <= '0;
         r_req_ack    <= '0;
         r_unit_z_ack <= 1'b0;
      end else begin
         r_req_ack    <= '0;
         r_unit_z_ack <= 1'b0;
         if (r_state == S_IDLE && w_found) begin
            r_grant_idx <= w_winner;
            r_op_a      <= w_win_a;
            r_op_b      <= w_win_b;
            r_req_ack   <= w_win_oh;
         end
         if (r_state == S_WAIT_Z && unit_z_stb) begin
            r_resp_z     <= unit_z;
            r_unit_z_ack <= 1'b1;
         end
         if (w_timeout) begin
            r_resp_z <= c_qnan;
         end
         if (w_resp_accept) begin
            r_last <= r_grant_idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT + 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_to_rst;
   logic               r_resp_err;
   logic               w_counting;
   logic               w_own_ack;

   assign w_counting = (r_state == S_SEND_A) || (r_state == S_SEND_B) || (r_state == S_WAIT_Z);
   assign w_own_ack  = ((r_state == S_SEND_A) && unit_a_ack) ||
                       ((r_state == S_SEND_B) && unit_b_ack) ||
                       ((r_state == S_WAIT_Z) && unit_z_stb);
   // A handshake landing on the final cycle still wins over the watchdog
   assign w_timeout  = w_counting && !w_own_ack && (r_cnt == c_cnt_w'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_to_rst   <= 1'b0;
         r_resp_err <= 1'b0;
      end else begin
         r_to_rst <= w_timeout;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (w_counting) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
         if (w_timeout) begin
            r_resp_err <= 1'b1;
         end else if ((r_state == S_WAIT_Z && unit_z_stb) || w_resp_accept) begin
            r_resp_err <= 1'b0;
         end
      end
   end

   assign resp_err = r_resp_err;
   assign w_to_rst = r_to_rst;
`else
   assign w_timeout = 1'b0;
   assign resp_err  = 1'b0;
   assign w_to_rst  = 1'b0;
`endif

   assign unit_rst   = rst | w_state_rst | w_to_rst;
   assign unit_a     = r_op_a;
   assign unit_b     = r_op_b;
   assign unit_z_ack = r_unit_z_ack;
   assign req_ack    = r_req_ack;
   assign resp_z     = r_resp_z;
   assign busy       = (r_state != S_IDLE);
   assign grant_idx  = r_grant_idx;

endmodule
`default_nettype wire

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Round-robin arbiter and sequencer that shares one stb/ack floating-point unit (the single-precision `multiplier`) between N_REQ requesters such as parallel matrix-multiplier lanes. It captures one operand pair, drives the unit's A/B/Z handshakes, and returns the 32-bit result to the granted requester. One operation is in flight at a time. The unit receives a one-cycle reset before every operation, matching how the datapath uses these cores.

## Interface
- N_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(N_REQ), grant index width
- TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_stb  in  N_REQ  requester n has an operand pair valid
- req_a  in  32*N_REQ  operand A; lane n at [32n+31:32n]
- req_b  in  32*N_REQ  operand B, same packing
- req_ack  out  N_REQ  one-hot one-cycle pulse: operands of lane n captured
- resp_z  out  32  result
- resp_stb  out  N_REQ  one-hot, result valid for lane n
- resp_ack  in  N_REQ  lane n accepts result
- resp_err  out  1  result is a timeout error; valid with resp_stb
- unit_a, unit_b  out  32  operands to the shared unit
- unit_a_stb, unit_b_stb  out  1  operand strobes
- unit_a_ack, unit_b_ack  in  1  operand acknowledges
- unit_z  in  32  unit result
- unit_z_stb  in  1  unit result valid
- unit_z_ack  out  1  result consumed
- unit_rst  out  1  reset to the shared unit
- busy  out  1  state != S_IDLE
- grant_idx  out  IDX_W  current/last granted lane

## Operation
- States: S_IDLE, S_UNIT_RST, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESP.
- S_IDLE: when any req_stb is high, select the winner by searching last+1, last+2, … last+N_REQ (mod N_REQ). Latch req_a/req_b of the winner into op_a/op_b. Set grant_idx. Pulse req_ack[winner] in the next cycle. Go to S_UNIT_RST.
- S_UNIT_RST: unit_rst=1 for exactly one cycle, then go to S_SEND_A.
- S_SEND_A: unit_a_stb=1. When unit_a_ack is sampled high, go to S_SEND_B.
- S_SEND_B: unit_b_stb=1. When unit_b_ack is sampled high, go to S_WAIT_Z.
- S_WAIT_Z: when unit_z_stb is sampled high, register resp_z<=unit_z and resp_err<=0. Pulse unit_z_ack for one cycle. Go to S_RESP.
- S_RESP: resp_stb[grant_idx]=1, held until resp_ack[grant_idx] is sampled high. Then set last<=grant_idx and go to S_IDLE.
- unit_a/unit_b are driven from op_a/op_b, which are stable for the whole operation.
- Strobes (unit_*_stb, unit_rst, resp_stb) are Moore outputs decoded from the state register. unit_z_ack and req_ack are registered pulses.
- resp_ack on non-granted lanes is ignored. req_stb changes during an operation are ignored.
- A requester whose req_stb stays high after its req_ack is treated as a new request at the next S_IDLE. It is served only after the other pending lanes (round robin).

## Timing
- Reset values: state=S_IDLE, last=N_REQ-1 (lane 0 has first priority), grant_idx=0, resp_z=0, resp_err=0, req_ack=0, resp_stb=0, unit_*_stb=0, unit_z_ack=0, busy=0.
- unit_rst=1 whenever rst=1, combinationally OR'd.
- Reset asserted mid-operation aborts it. No resp_stb is issued for the aborted request.
- Arbiter overhead is 5 cycles beyond unit handshake time: 1 each in S_IDLE, S_UNIT_RST, S_SEND_A, S_SEND_B and S_RESP, with zero-wait acks.
- Next grant is no earlier than 1 cycle after resp_ack is sampled.
- unit_a_ack/unit_b_ack/unit_z_stb arriving in any state other than their own are ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to S_SEND_A, S_SEND_B and S_WAIT_Z.
  - If it reaches TIMEOUT in any of these states: resp_z<=32'h7FC00000 (qNaN), resp_err<=1, unit_rst pulses for 1 cycle, go to S_RESP.
  - resp_err clears when resp_ack is accepted.
- ARB_TIMEOUT_EN undefined: no counter; resp_err is tied to 0; the arbiter waits indefinitely.

## Test plan
- Single request: lane 0, A=32'h3FC00000 (1.5), B=32'h40000000 (2.0), unit with 1-cycle acks. Required: req_ack[0] one pulse, unit_rst pulse, resp_z=32'h40400000, resp_stb=4'b0001, resp_err=0.
- Round robin: all 4 lanes request continuously. Required: grants in order 0,1,2,3,0; each lane sees exactly one req_ack per grant.
- Backpressure: hold unit_a_ack low for 10 cycles and resp_ack low for 5 cycles. Required: unit_a_stb held for 10 cycles; resp_stb and resp_z held stable for 5 cycles; no new grant until resp_ack.
- Stray ack: assert resp_ack[2] while lane 1 is granted. Required: no state change; resp_stb[1] stays high.
- Reset mid-op: assert rst in S_WAIT_Z. Required: next cycle busy=0, all strobes 0, unit_rst=1 during rst; lane 0 has priority afterwards.
- ARB_TIMEOUT_EN, TIMEOUT=16, unit never asserts unit_z_stb. Required: after 16 cycles in S_WAIT_Z, resp_z=32'h7FC00000, resp_err=1, one unit_rst pulse.
